// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone classic master engine.
// The command struct is sized by WB_ADR_W / WB_DAT_W, which are also the
// default address/data widths of wb_master_standard.
package wb_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 16;

  // Bus sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CYCLE = 2'd1,
    GAP   = 2'd2
  } wb_state_t;

  // One queued bus command
  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_cmd_t;

  localparam int WB_CMD_W = $bits(wb_cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO, 2**depth_log2 entries of width bits.
// Read and write pointers carry one extra wrap bit so that full and empty
// can be told apart when the index bits are equal. A push while full is
// accepted when a pop happens on the same edge: the slot being vacated is
// the one being written, and the head is read combinationally beforehand.
module wb_cmd_fifo #(
  parameter int width      = 8,
  parameter int depth_log2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int depth = 1 << depth_log2;

  logic [depth_log2:0]   wr_ptr;
  logic [depth_log2:0]   rd_ptr;
  logic [width-1:0]      mem [depth];
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[depth_log2] != rd_ptr[depth_log2]) &&
                 (wr_ptr[depth_log2-1:0] == rd_ptr[depth_log2-1:0]);

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign dout = mem[rd_ptr[depth_log2-1:0]];

  // Pointer update; wrap happens naturally through the extra bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, no reset needed since empty guards every read
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[depth_log2-1:0]] <= din;
  end

endmodule

// File: rtl/wb_master_standard.sv
// Wishbone classic single-cycle master engine.
// Commands enter through a valid/ready port into wb_cmd_fifo and are
// issued one at a time as CYC/STB cycles; each completion produces a
// one-clock response pulse.
// Optional build macro WB_MASTER_TIMEOUT_EN adds a watchdog that ends a
// cycle with rsp_err = 1 after timeout_cycles clocks without wb_ack.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus quiet, launch the FIFO head as soon as one is present
// CYCLE | CYC/STB asserted, bus signals frozen, waiting for wb_ack
// GAP   | the single idle clock between cycles; may launch the next one
module wb_master_standard
  import wb_pkg::*;
#(
  parameter int adr_width       = WB_ADR_W,
  parameter int dat_width       = WB_DAT_W,
  parameter int fifo_depth_log2 = 2,
  parameter int timeout_cycles  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [adr_width-1:0] cmd_adr,
  input  logic [dat_width-1:0] cmd_dat,
  output logic                 rsp_valid,
  output logic                 rsp_we,
  output logic [dat_width-1:0] rsp_dat,
  output logic                 rsp_err,
  output logic [adr_width-1:0] wb_adr,
  output logic [dat_width-1:0] wb_dat_m,
  input  logic [dat_width-1:0] wb_dat_s,
  output logic                 wb_we,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  input  logic                 wb_ack
);

  wb_state_t state;
  wb_cmd_t   push_cmd;
  wb_cmd_t   head_cmd;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;

  assign push_cmd  = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  // GAP already counts as the idle clock, so a pending head launches there
  // directly; this keeps back-to-back cycles exactly one clock apart.
  assign fifo_pop  = (state != CYCLE) && !fifo_empty;

  wb_cmd_fifo #(
    .width      (WB_CMD_W),
    .depth_log2 (fifo_depth_log2)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_cmd),
    .pop   (fifo_pop),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int tmr_w = $clog2(timeout_cycles + 1);
  localparam logic [tmr_w-1:0] tmr_last = tmr_w'(timeout_cycles - 1);
  logic [tmr_w-1:0] timer;
`else
  wire unused_timeout = (timeout_cycles != 0);
  assign rsp_err = 1'b0;
`endif

  // Bus sequencer with registered bus and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wb_adr    <= '0;
      wb_dat_m  <= '0;
      wb_we     <= 1'b0;
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_dat   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      rsp_err   <= 1'b0;
      timer     <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (!fifo_empty) begin
            wb_adr   <= head_cmd.adr;
            wb_dat_m <= head_cmd.dat;
            wb_we    <= head_cmd.we;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            state    <= CYCLE;
`ifdef WB_MASTER_TIMEOUT_EN
            timer    <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CYCLE: begin
          if (wb_ack) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= wb_we;
            rsp_dat   <= wb_we ? '0 : wb_dat_s;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= GAP;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (timer == tmr_last) begin
            // Watchdog expiry: end the cycle as if acked, but flag it
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= wb_we;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
            state     <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
